// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the BRAM arbiter and the memory it drives:
// default word/address widths and the controller state encoding.
package bram_arbiter_pkg;

    localparam int DEF_WORD_WIDTH = 24;
    localparam int DEF_ADDR_WIDTH = 8;

    // INIT zeroes the memory, SERVE arbitrates the two request ports.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision. last_b=1 means port B won the most recent
// grant, so on a tie port A wins; last_b=0 hands a tie to port B.
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic gnt_a,
    output logic gnt_b
);

    // One-hot grant: a lone requester always wins, a tie goes to the other port.
    always_comb begin
        gnt_a = req_a & (~req_b | last_b);
        gnt_b = req_b & (~req_a | ~last_b);
    end

endmodule

// File: rtl/bram_arbiter.sv
// Dual-port front end for a single-port BRAM. After reset it sweeps every
// address writing zero, then arbitrates ports A and B round-robin, issuing
// one memory access per grant and returning read data one cycle later.
import bram_arbiter_pkg::*;

module bram_arbiter #(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [WORD_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [WORD_WIDTH-1:0] b_rdata,
    output logic                  init_done,
    output logic                  mem_read_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out
);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [ADDR_WIDTH-1:0] sweep_count;
    logic                  sweep_last;
    logic [ADDR_WIDTH-1:0] held_addr_p1;
    logic                  last_b;
    logic                  serve;
    logic                  a_vld_p1;
    logic                  b_vld_p1;

    assign serve      = (state == ST_SERVE);
    assign sweep_last = (sweep_count == {ADDR_WIDTH{1'b1}});

    // Requests are masked during the sweep so nothing is granted before the
    // memory contents are defined.
    rr_arb2 u_rr_arb2 (
        .req_a  (a_req & serve),
        .req_b  (b_req & serve),
        .last_b (last_b),
        .gnt_a  (a_gnt),
        .gnt_b  (b_gnt)
    );

    // Next-state: leave INIT after the write to the top address.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:  if (sweep_last) next_state = ST_SERVE;
            ST_SERVE: next_state = ST_SERVE;
            default:  next_state = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clear) state <= ST_INIT;
        else       state <= next_state;
    end

    // Sweep address counter; only advances while sweeping, so it can never
    // begin a second pass once SERVE is reached.
    always_ff @(posedge clk) begin
        if (clear)                 sweep_count <= '0;
        else if (state == ST_INIT) sweep_count <= sweep_count + 1'b1;
    end

    // Registered completion flag, high exactly in SERVE cycles.
    always_ff @(posedge clk) begin
        if (clear) init_done <= 1'b0;
        else       init_done <= (next_state == ST_SERVE);
    end

    // Last-grant pointer; reset value makes A win the first tie.
    always_ff @(posedge clk) begin
        if (clear)      last_b <= 1'b1;
        else if (a_gnt) last_b <= 1'b0;
        else if (b_gnt) last_b <= 1'b1;
    end

    // ---- stage p0 -> p1: read grant becomes read-data valid ----
    // A clear sampled alongside a read grant kills its valid.
    always_ff @(posedge clk) begin
        if (clear) begin
            a_vld_p1 <= 1'b0;
            b_vld_p1 <= 1'b0;
        end else begin
            a_vld_p1 <= a_gnt & ~a_we;
            b_vld_p1 <= b_gnt & ~b_we;
        end
    end

    // Remember the last address presented so idle cycles keep it stable.
    always_ff @(posedge clk) begin
        held_addr_p1 <= mem_address;
    end

    // Memory command mux: sweep write, granted port, or idle read.
    always_comb begin
        mem_read_write = 1'b0;
        mem_address    = held_addr_p1;
        mem_data_in    = '0;
        if (!serve) begin
            mem_read_write = 1'b1;
            mem_address    = sweep_count;
        end else if (a_gnt) begin
            mem_read_write = a_we;
            mem_address    = a_addr;
            mem_data_in    = a_wdata;
        end else if (b_gnt) begin
            mem_read_write = b_we;
            mem_address    = b_addr;
            mem_data_in    = b_wdata;
        end
    end

    assign a_rvalid = a_vld_p1;
    assign b_rvalid = b_vld_p1;
    assign a_rdata  = mem_data_out;
    assign b_rdata  = mem_data_out;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a registered-read memory model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [23:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [23:0] a_rdata, b_rdata;
    logic        init_done;
    logic        mem_read_write;
    logic [7:0]  mem_address;
    logic [23:0] mem_data_in, mem_data_out;

    logic        prefill;
    logic [23:0] mem [256];
    logic        zeroed [256];
    logic        init_gnt_seen;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.WORD_WIDTH(24), .ADDR_WIDTH(8)) dut (
        .clk(clk), .clear(clear),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_done(init_done), .mem_read_write(mem_read_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Memory model: write commits at the edge, read data registered.
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 24'h5A5A5A;
        end else if (mem_read_write) begin
            mem[mem_address] <= mem_data_in;
        end else begin
            mem_data_out <= mem[mem_address];
        end
    end

    // Sweep coverage and illegal-grant monitor.
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 256; i++) zeroed[i] <= 1'b0;
            init_gnt_seen <= 1'b0;
        end else if (!init_done) begin
            if (mem_read_write && mem_data_in == 24'd0) zeroed[mem_address] <= 1'b1;
            if (a_gnt || b_gnt) init_gnt_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles from the first INIT cycle until init_done is seen high,
    // optionally raising an A read of address 5 at cycle req_at.
    task automatic run_init(input int req_at, output int n);
        n = 1;
        while (init_done !== 1'b1 && n < 600) begin
            if (n == req_at) begin
                a_req  = 1'b1;
                a_we   = 1'b0;
                a_addr = 8'h05;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic pa, pb;

        clear = 1'b1; prefill = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tick();
        prefill = 1'b0;
        tick();

        // Held clear: INIT behaviour, no grant even with a request.
        a_req = 1'b1;
        #1;
        chk("clr_gnt", a_gnt, 0);
        chk("clr_addr", mem_address, 0);
        chk("clr_rw", mem_read_write, 1);
        chk("clr_done", init_done, 0);
        tick();
        a_req = 1'b0;
        clear = 1'b0;

        // Sweep with an A read waiting from cycle 3.
        run_init(3, n);
        chk("init_cycles", n, 257);
        cnt = 0;
        for (int i = 0; i < 256; i++) if (zeroed[i] && mem[i] == 24'd0) cnt++;
        chk("sweep_zero", cnt, 256);
        chk("init_no_gnt", init_gnt_seen, 0);
        #1;
        chk("wait_a_gnt", a_gnt, 1);
        chk("wait_addr", mem_address, 8'h05);
        chk("wait_rw", mem_read_write, 0);
        tick();
        a_req = 1'b0;
        chk("wait_rvalid", a_rvalid, 1);
        chk("wait_rdata", a_rdata, 0);
        chk("wait_b_rv", b_rvalid, 0);

        // A writes 0xABCDEF to 0x10 then reads it back.
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 24'hABCDEF;
        #1;
        chk("aw_gnt", a_gnt, 1);
        chk("aw_rw", mem_read_write, 1);
        chk("aw_din", mem_data_in, 24'hABCDEF);
        tick();
        a_we = 1'b0;
        #1;
        chk("ar_gnt", a_gnt, 1);
        chk("aw_no_rv", a_rvalid, 0);
        tick();
        a_req = 1'b0;
        chk("ar_rvalid", a_rvalid, 1);
        chk("ar_rdata", a_rdata, 24'hABCDEF);
        chk("ar_b_rv", b_rvalid, 0);
        #1;
        chk("idle_rw", mem_read_write, 0);
        chk("idle_addr", mem_address, 8'h10);
        chk("idle_din", mem_data_in, 0);
        tick();

        // B writes 0xFF, A reads 0xFF on the next cycle.
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 24'h123456;
        #1;
        chk("bw_gnt", b_gnt, 1);
        chk("bw_a_gnt", a_gnt, 0);
        tick();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'hFF;
        #1;
        chk("ff_a_gnt", a_gnt, 1);
        chk("bw_no_rv", b_rvalid, 0);
        tick();
        a_req = 1'b0;
        chk("ff_rvalid", a_rvalid, 1);
        chk("ff_rdata", a_rdata, 24'h123456);
        chk("ff_b_rv", b_rvalid, 0);

        // Clear in SERVE, then clear again at sweep address 100.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (mem_address != 8'd100 && n < 300) begin
            tick();
            n++;
        end
        chk("sw100_addr", mem_address, 100);
        chk("sw100_done", init_done, 0);
        clear = 1'b1;
        tick();
        chk("restart_addr", mem_address, 0);
        chk("restart_rw", mem_read_write, 1);
        chk("restart_done", init_done, 0);
        clear = 1'b0;
        run_init(0, n);
        chk("reinit_cycles", n, 257);

        // Continuous tie: A,B,A,B,A,B with rvalid routed per port.
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        pa = 1'b0; pb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("tie_a_gnt", a_gnt, (i % 2) == 0);
            chk("tie_b_gnt", b_gnt, (i % 2) == 1);
            chk("tie_a_rv", a_rvalid, pa);
            chk("tie_b_rv", b_rvalid, pb);
            pa = ((i % 2) == 0);
            pb = ~pa;
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("tie_last_a_rv", a_rvalid, 0);
        chk("tie_last_b_rv", b_rvalid, 1);

        // Clear sampled together with a read grant: no rvalid, sweep restarts.
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        clear = 1'b1;
        #1;
        chk("clrrd_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0;
        chk("clrrd_rv", a_rvalid, 0);
        chk("clrrd_done", init_done, 0);
        chk("clrrd_addr", mem_address, 0);
        clear = 1'b0;
        run_init(0, n);
        chk("clrrd_cycles", n, 257);

        // Freshly zeroed memory reads back zero.
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        #1;
        chk("final_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0;
        chk("final_rv", a_rvalid, 1);
        chk("final_rdata", a_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
